// File: rtl/sram_frame_reader.sv
// Streams one frame of packed 8-bit pixels from SRAM words, with credit-limited reads.
// Define FRAME_READER_CHECKSUM_EN to build the running byte-sum checksum.
module sram_frame_reader #(
    parameter int          N_PIXEL   = 480000,
    parameter logic [17:0] BASE_ADDR = 18'd0,
    parameter int          MAX_OUT   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        start_ack,
    output logic        done,
    input  logic        done_ack,
    output logic [17:0] addr,
    output logic        addr_valid,
    input  logic        addr_ready,
    input  logic [31:0] data,
    input  logic        data_valid,
    output logic        data_ready,
    output logic [7:0]  pixel,
    output logic        pixel_valid,
    input  logic        pixel_ready,
    output logic [15:0] checksum
);

    localparam int N_WORDS = N_PIXEL / 4;
    localparam int AW = $clog2(N_WORDS + 1);
    localparam int PW = $clog2(N_PIXEL + 1);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int FW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nx;

    logic [AW-1:0] addr_cnt;
    logic [PW-1:0] pix_cnt;
    logic [CW-1:0] in_flight;
    logic [CW-1:0] fcount;
    logic [FW-1:0] wr_ptr;
    logic [FW-1:0] rd_ptr;
    logic [1:0]    byte_idx;
    logic [31:0]   fifo_mem [MAX_OUT];
    logic [31:0]   head;
    logic [7:0]    pixel_i;

    logic go, words_left, credit_ok, addr_valid_i;
    logic addr_fire, push, pix_valid_i, pix_fire, pop, last_pix;

    function automatic logic [FW-1:0] ptr_inc(input logic [FW-1:0] p);
        return (p == FW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    assign go           = (state == IDLE) && start;
    assign words_left   = addr_cnt < AW'(N_WORDS);
    assign credit_ok    = ({1'b0, in_flight} + {1'b0, fcount})
                          < (CW+1)'(MAX_OUT);
    assign addr_valid_i = (state == RUN) && words_left && credit_ok;
    assign addr_fire    = addr_valid_i && addr_ready;
    // A word with no matching request in flight is stale and dropped.
    assign push         = (state == RUN) && data_valid
                          && (in_flight != '0);
    assign pix_valid_i  = (state == RUN) && (fcount != '0);
    assign pix_fire     = pix_valid_i && pixel_ready;
    assign pop          = pix_fire && (byte_idx == 2'd3);
    assign last_pix     = pix_fire && (pix_cnt == PW'(N_PIXEL - 1));

    assign head    = fifo_mem[rd_ptr];
    assign pixel_i = head[{byte_idx, 3'b000} +: 8];

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start)    state_nx = RUN;
            RUN:     if (last_pix) state_nx = DONE;
            DONE:    if (done_ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || go) begin
            addr_cnt  <= '0;
            pix_cnt   <= '0;
            in_flight <= '0;
            fcount    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            byte_idx  <= '0;
        end else begin
            if (addr_fire) addr_cnt <= addr_cnt + 1'b1;
            in_flight <= in_flight + CW'(addr_fire) - CW'(push);
            fcount    <= fcount + CW'(push) - CW'(pop);
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (pix_fire) begin
                byte_idx <= byte_idx + 1'b1;
                pix_cnt  <= pix_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= data;
    end

`ifdef FRAME_READER_CHECKSUM_EN
    logic [15:0] csum;

    always_ff @(posedge clock) begin
        if (reset || go)   csum <= '0;
        else if (pix_fire) csum <= csum + {8'd0, pixel_i};
    end

    assign checksum = reset ? 16'd0 : csum;
`else
    assign checksum = 16'd0;
`endif

    // Outputs are forced low while reset is asserted.
    assign start_ack   = !reset && go;
    assign done        = !reset && (state == DONE);
    assign addr_valid  = !reset && addr_valid_i;
    assign addr        = reset ? 18'd0 : BASE_ADDR + 18'(addr_cnt);
    assign data_ready  = !reset && (state == RUN);
    assign pixel_valid = !reset && pix_valid_i;
    assign pixel       = reset ? 8'd0 : pixel_i;

endmodule

// File: tb/tb_sram_frame_reader.sv
// Directed bench for sram_frame_reader: frames, stalls, mid-frame reset,
// done hold, checksum and read-credit limit.
module tb_sram_frame_reader;

`ifdef FRAME_READER_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    logic        clock;
    logic        reset, start, done_ack, addr_ready, data_valid, pixel_ready;
    logic [31:0] data;
    logic        start_ack, done, addr_valid, data_ready, pixel_valid;
    logic [17:0] addr;
    logic [7:0]  pixel;
    logic [15:0] checksum;

    logic        reset_b, start_b, addr_ready_b, data_valid_b, pixel_ready_b;
    logic [31:0] data_b;
    logic        start_ack_b, done_b, addr_valid_b, data_ready_b, pixel_valid_b;
    logic [17:0] addr_b;
    logic [7:0]  pixel_b;
    logic [15:0] checksum_b;

    sram_frame_reader #(
        .N_PIXEL(8), .BASE_ADDR(18'h100), .MAX_OUT(4)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .start_ack(start_ack),
        .done(done), .done_ack(done_ack), .addr(addr),
        .addr_valid(addr_valid), .addr_ready(addr_ready), .data(data),
        .data_valid(data_valid), .data_ready(data_ready), .pixel(pixel),
        .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .checksum(checksum)
    );

    sram_frame_reader #(
        .N_PIXEL(32), .BASE_ADDR(18'h100), .MAX_OUT(4)
    ) dut_b (
        .clock(clock), .reset(reset_b), .start(start_b),
        .start_ack(start_ack_b), .done(done_b), .done_ack(done_ack),
        .addr(addr_b), .addr_valid(addr_valid_b),
        .addr_ready(addr_ready_b), .data(data_b),
        .data_valid(data_valid_b), .data_ready(data_ready_b),
        .pixel(pixel_b), .pixel_valid(pixel_valid_b),
        .pixel_ready(pixel_ready_b), .checksum(checksum_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] words [2];
    logic [17:0] rq [$];
    int          rdue [$];
    int          lat, cyc, n_addr, n_pix, maxq, nb;
    bit          tog, stalled;
    logic [7:0]  held;
    logic [31:0] wb;
    int          n_checks, n_err;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] cs(input logic [15:0] v);
        return CS_EN ? v : 16'd0;
    endfunction

    function automatic logic [7:0] exp_byte(input int n);
        logic [31:0] w;
        w = words[n[2]];
        return w[8*n[1:0] +: 8];
    endfunction

    // Pixel sink plus an arbiter returning words 'lat' cycles after accept.
    task automatic model();
        cyc++;
        pixel_ready = tog ? !pixel_ready : 1'b1;
        if (stalled && !reset) begin
            check("hold_valid", 32'(pixel_valid), 32'd1);
            check("hold_pixel", 32'(pixel), 32'(held));
        end
        if (pixel_valid && pixel_ready) begin
            if (n_pix < 8)
                check("pixel", 32'(pixel), 32'(exp_byte(n_pix)));
            else
                check("extra_pixel", 32'(pixel_valid), 32'd0);
            n_pix++;
        end
        stalled = pixel_valid && !pixel_ready;
        held    = pixel;
        if (addr_valid && addr_ready) begin
            check("addr", 32'(addr), 32'h100 + 32'(n_addr));
            n_addr++;
            rq.push_back(addr);
            rdue.push_back(cyc + lat);
            if (rq.size() > maxq) maxq = rq.size();
        end
        data_valid = 1'b0;
        data       = '0;
        if (rq.size() != 0 && rdue[0] <= cyc) begin
            data       = words[rq[0][0]];
            data_valid = 1'b1;
            void'(rq.pop_front());
            void'(rdue.pop_front());
        end
    endtask

    task automatic step();
        @(negedge clock);
        model();
    endtask

    task automatic start_frame();
        n_addr  = 0;
        n_pix   = 0;
        stalled = 1'b0;
        maxq    = 0;
        step();
        start = 1'b1;
        #1 check("start_ack", 32'(start_ack), 32'd1);
        step();
        check("ack_once", 32'(start_ack), 32'd0);
        start = 1'b0;
    endtask

    task automatic finish_frame(input logic [15:0] exp_cs);
        for (int i = 0; i < 400 && !done; i++) step();
        check("done", 32'(done), 32'd1);
        check("pix_count", 32'(n_pix), 32'd8);
        check("addr_count", 32'(n_addr), 32'd2);
        check("valid_in_done", 32'(pixel_valid), 32'd0);
        check("checksum", 32'(checksum), 32'(exp_cs));
    endtask

    task automatic ack_done(input logic [15:0] exp_cs);
        done_ack = 1'b1;
        step();
        done_ack = 1'b0;
        check("idle_after_ack", 32'(done), 32'd0);
        check("checksum_idle", 32'(checksum), 32'(exp_cs));
    endtask

    initial begin
        n_checks = 0; n_err = 0; cyc = 0; maxq = 0;
        reset = 1'b1; start = 1'b0; done_ack = 1'b0; addr_ready = 1'b1;
        data_valid = 1'b0; data = '0; pixel_ready = 1'b1;
        lat = 1; tog = 1'b0; stalled = 1'b0; held = '0;
        n_addr = 0; n_pix = 0;
        reset_b = 1'b1; start_b = 1'b0; addr_ready_b = 1'b1;
        data_valid_b = 1'b0; data_b = '0; pixel_ready_b = 1'b0;
        words[0] = 32'h04030201;
        words[1] = 32'h08070605;
        repeat (3) @(negedge clock);
        check("rst_start_ack", 32'(start_ack), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr_valid", 32'(addr_valid), 32'd0);
        check("rst_data_ready", 32'(data_ready), 32'd0);
        check("rst_pixel_valid", 32'(pixel_valid), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_pixel", 32'(pixel), 32'd0);
        check("rst_checksum", 32'(checksum), 32'd0);
        reset = 1'b0;

        start_frame();
        finish_frame(cs(16'h0024));

        for (int i = 0; i < 20; i++) begin
            step();
            start = i[0];
            #1 check("done_hold", 32'(done), 32'd1);
            check("no_ack_in_done", 32'(start_ack), 32'd0);
        end
        start = 1'b0;
        step();
        ack_done(cs(16'h0024));

        lat = 10;
        tog = 1'b1;
        start_frame();
        finish_frame(cs(16'h0024));
        check("outstanding_le4", 32'(maxq <= 4), 32'd1);
        tog = 1'b0;
        ack_done(cs(16'h0024));

        lat = 3;
        start_frame();
        for (int i = 0; i < 200 && n_pix < 3; i++) step();
        check("reached_pixel3", 32'(n_pix), 32'd3);
        reset = 1'b1;
        step();
        step();
        check("mid_rst_addr_valid", 32'(addr_valid), 32'd0);
        check("mid_rst_checksum", 32'(checksum), 32'd0);
        reset = 1'b0;
        repeat (8) step();
        check("stale_sent", 32'(rq.size()), 32'd0);
        check("stale_dropped", 32'(pixel_valid), 32'd0);
        check("idle_data_ready", 32'(data_ready), 32'd0);
        start_frame();
        finish_frame(cs(16'h0024));
        ack_done(cs(16'h0024));

        words[0] = 32'hFFFFFFFF;
        words[1] = 32'hFFFFFFFF;
        lat = 1;
        start_frame();
        finish_frame(cs(16'h07F8));
        ack_done(cs(16'h07F8));

        reset_b = 1'b0;
        @(negedge clock);
        start_b = 1'b1;
        #1 check("b_start_ack", 32'(start_ack_b), 32'd1);
        @(negedge clock);
        start_b = 1'b0;
        nb = 0;
        for (int i = 0; i < 12; i++) begin
            if (addr_valid_b && addr_ready_b) begin
                check("b_addr", 32'(addr_b), 32'h100 + 32'(nb));
                nb++;
            end
            @(negedge clock);
        end
        check("b_inflight", 32'(nb), 32'd4);
        check("b_valid_low", 32'(addr_valid_b), 32'd0);
        check("b_data_ready", 32'(data_ready_b), 32'd1);
        wb = 32'h44332211;
        data_b = wb;
        data_valid_b = 1'b1;
        @(negedge clock);
        data_valid_b = 1'b0;
        check("b_pixel_valid", 32'(pixel_valid_b), 32'd1);
        check("b_still_full", 32'(addr_valid_b), 32'd0);
        pixel_ready_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("b_pixel", 32'(pixel_b), 32'(wb[8*k +: 8]));
            @(negedge clock);
        end
        pixel_ready_b = 1'b0;
        check("b_credit_back", 32'(addr_valid_b), 32'd1);
        check("b_next_addr", 32'(addr_b), 32'h104);
        check("b_checksum", 32'(checksum_b), 32'(cs(16'h00AA)));
        check("b_not_done", 32'(done_b), 32'd0);
        reset_b = 1'b1;
        @(negedge clock);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
